fsk_frame_ctrl: RTL

Transmit-side frame sequencer for the FSK link. It accepts 12-bit Hamming-coded words from the encode chain over a valid/ready handshake and buffers one word. It frames each word with a sync pattern and an inter-frame gap, then serializes the frame MSB-first at a programmable bit rate. It sits between the Hamming encoder and the FSK modulator and replaces ad-hoc derived bit clocks with a single-clock bit strobe.

---
 rtl/fsk_frame_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fsk_frame_ctrl.sv
// Transmit frame sequencer: sync pattern, coded word, gap bits, sent MSB-first at BIT_DIV clocks per bit.
// Define FSK_PARITY_EN to insert an even-parity bit after the data field.
module fsk_frame_ctrl #(
  parameter int                WORD_W       = 12,
  parameter int                SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5,
  parameter int                BIT_DIV      = 16,
  parameter int                GAP_BITS     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              tx_bit,
  output logic              bit_strobe,
  output logic              frame_start,
  output logic              tx_active
);

`ifdef FSK_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // The sync MSB goes straight into r_tx_bit on load, so the shifter holds only what follows it.
  localparam int SH_W     = SYNC_W - 1 + WORD_W + PAR_BITS;
  localparam int MAX_BITS = (WORD_W > SYNC_W) ? ((WORD_W > GAP_BITS) ? WORD_W : GAP_BITS)
                                              : ((SYNC_W > GAP_BITS) ? SYNC_W : GAP_BITS);
  localparam int BC_W     = $clog2(MAX_BITS + 1);
  localparam int DIV_W    = $clog2(BIT_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_DIV - 1);
  localparam logic [BC_W-1:0]  SYNC_LAST = BC_W'(SYNC_W - 1);
  localparam logic [BC_W-1:0]  WORD_LAST = BC_W'(WORD_W - 1);
  localparam logic [BC_W-1:0]  GAP_LAST  = BC_W'(GAP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_PAR, S_GAP} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [BC_W-1:0]   r_bit_cnt;
  logic              r_hold_full;
  logic [WORD_W-1:0] r_hold;
  logic [SH_W-1:0]   r_shift;
  logic              r_tx_bit;
  logic              w_bit_end;
  logic              w_state_last;
  logic              w_load;
  logic              w_accept;

  assign w_bit_end = (r_state != S_IDLE) && (r_div_cnt == DIV_LAST);
  assign w_accept  = word_valid && !r_hold_full;
  assign w_load    = (w_next_state == S_SYNC) && (r_state != S_SYNC);

  always_comb begin
    w_state_last = 1'b0;
    case (r_state)
      S_SYNC:  w_state_last = (r_bit_cnt == SYNC_LAST);
      S_DATA:  w_state_last = (r_bit_cnt == WORD_LAST);
      S_PAR:   w_state_last = 1'b1;
      S_GAP:   w_state_last = (r_bit_cnt == GAP_LAST);
      default: w_state_last = 1'b0;
    endcase
  end

  // State register and control counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_hold_full <= 1'b0;
      r_tx_bit    <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE || w_bit_end) r_div_cnt <= '0;
      else                                r_div_cnt <= r_div_cnt + DIV_W'(1);
      if (w_next_state != r_state) r_bit_cnt <= '0;
      else if (w_bit_end)          r_bit_cnt <= r_bit_cnt + BC_W'(1);
      if (w_load)        r_hold_full <= 1'b0;
      else if (w_accept) r_hold_full <= 1'b1;
      if (w_load)
        r_tx_bit <= SYNC_PATTERN[SYNC_W-1];
      else if (w_bit_end)
        r_tx_bit <= (w_next_state == S_GAP || w_next_state == S_IDLE) ? 1'b1 : r_shift[SH_W-1];
    end
  end

  // Data path: holding register and frame shifter carry no reset
  always_ff @(posedge clk) begin
    if (w_accept) r_hold <= word_in;
    if (w_load) begin
`ifdef FSK_PARITY_EN
      r_shift <= {SYNC_PATTERN[SYNC_W-2:0], r_hold, ^r_hold};
`else
      r_shift <= {SYNC_PATTERN[SYNC_W-2:0], r_hold};
`endif
    end else if (w_bit_end) begin
      r_shift <= {r_shift[SH_W-2:0], 1'b1};
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (r_hold_full) w_next_state = S_SYNC;
      S_SYNC: if (w_bit_end && w_state_last) w_next_state = S_DATA;
`ifdef FSK_PARITY_EN
      S_DATA: if (w_bit_end && w_state_last) w_next_state = S_PAR;
`else
      S_DATA: if (w_bit_end && w_state_last) w_next_state = S_GAP;
`endif
      S_PAR:  if (w_bit_end) w_next_state = S_GAP;
      S_GAP:  if (w_bit_end && w_state_last) w_next_state = r_hold_full ? S_SYNC : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    word_ready  = !r_hold_full;
    tx_bit      = r_tx_bit;
    tx_active   = (r_state != S_IDLE);
    bit_strobe  = (r_state != S_IDLE) && (r_div_cnt == '0);
    frame_start = (r_state == S_SYNC) && (r_bit_cnt == '0) && (r_div_cnt == '0);
  end

endmodule
